// File: rtl/asynchronous_fifo.sv
// Single-clock FIFO with registered read data, a write-accept pulse and
// almost-empty / almost-full flags decoded from the occupancy count.
module asynchronous_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3,
    parameter int AE_LEVEL   = 1,
    parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 1
) (
    input  logic                  clock,
    input  logic                  Clear_in,
    input  logic [DATA_WIDTH-1:0] Data_in,
    input  logic                  enable_write,
    output logic                  ack_write,
    output logic                  Full_out,
    input  logic                  enable_read,
    output logic [DATA_WIDTH-1:0] Data_out,
    output logic                  Empty_out
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AE_C    = AE_LEVEL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AF_C    = AF_LEVEL[ADDR_WIDTH:0];

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wp;
    logic [ADDR_WIDTH-1:0] rp;
    logic [ADDR_WIDTH:0]   cnt;
    logic                  wr_ok;
    logic                  rd_ok;

    // Acceptance uses the true full/empty state; the flags are advisory only.
    assign wr_ok = enable_write && (cnt < DEPTH_C);
    assign rd_ok = enable_read  && (cnt != '0);

    assign Empty_out = (cnt <= AE_C);
    assign Full_out  = (cnt >= AF_C);

    // Storage is never cleared; stale words are unreachable once pointers reset.
    always_ff @(posedge clock) begin
        if (wr_ok && !Clear_in) begin
            mem[wp] <= Data_in;
        end
    end

    always_ff @(posedge clock) begin
        if (Clear_in) begin
            wp        <= '0;
            rp        <= '0;
            cnt       <= '0;
            Data_out  <= '0;
            ack_write <= 1'b0;
        end else begin
            ack_write <= wr_ok;
            if (wr_ok) begin
                wp <= wp + 1'b1;
            end
            if (rd_ok) begin
                Data_out <= mem[rp];
                rp       <= rp + 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: tb/tb_asynchronous_fifo.sv
// Directed plus randomized bench for asynchronous_fifo against a queue model.
module tb_asynchronous_fifo;
    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int AE    = 1;
    localparam int AF    = 7;

    logic          clock = 1'b0;
    logic          Clear_in = 1'b0;
    logic [DW-1:0] Data_in = '0;
    logic          enable_write = 1'b0;
    logic          ack_write;
    logic          Full_out;
    logic          enable_read = 1'b0;
    logic [DW-1:0] Data_out;
    logic          Empty_out;

    asynchronous_fifo dut (
        .clock        (clock),
        .Clear_in     (Clear_in),
        .Data_in      (Data_in),
        .enable_write (enable_write),
        .ack_write    (ack_write),
        .Full_out     (Full_out),
        .enable_read  (enable_read),
        .Data_out     (Data_out),
        .Empty_out    (Empty_out)
    );

    always #5 clock = ~clock;

    int            errors = 0;
    int            checks = 0;
    logic [DW-1:0] q[$];
    logic [DW-1:0] exp_dout;
    logic          exp_ack;
    int            acks;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model by the FIFO rules, compare outputs.
    task automatic cycle(input logic we, input logic re, input logic clr, input logic [DW-1:0] d);
        bit wok, rok;
        enable_write = we;
        enable_read  = re;
        Clear_in     = clr;
        Data_in      = d;
        @(posedge clock);
        #1;
        if (clr) begin
            q.delete();
            exp_dout = '0;
            exp_ack  = 1'b0;
        end else begin
            wok = we && (q.size() < DEPTH);
            rok = re && (q.size() > 0);
            if (rok) exp_dout = q.pop_front();
            if (wok) q.push_back(d);
            exp_ack = wok;
        end
        if (ack_write === 1'b1) acks++;
        check("data_out", 64'(Data_out), 64'(exp_dout));
        check("ack_write", 64'(ack_write), 64'(exp_ack));
        check("empty_out", 64'(Empty_out), 64'(q.size() <= AE));
        check("full_out", 64'(Full_out), 64'(q.size() >= AF));
        check("count", 64'(dut.cnt), 64'(q.size()));
        enable_write = 1'b0;
        enable_read  = 1'b0;
        Clear_in     = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] held;
        exp_dout = '0;
        exp_ack  = 1'b0;
        acks     = 0;

        // reset then idle
        cycle(1'b0, 1'b0, 1'b1, '0);
        cycle(1'b0, 1'b0, 1'b0, '0);
        check("rst_empty", 64'(Empty_out), 64'd1);
        check("rst_full", 64'(Full_out), 64'd0);
        check("rst_dout", 64'(Data_out), 64'd0);

        // three known words
        acks = 0;
        cycle(1'b1, 1'b0, 1'b0, 32'h0FCB01AA);
        cycle(1'b1, 1'b0, 1'b0, 32'h0FCBCAFE);
        cycle(1'b1, 1'b0, 1'b0, 32'h011CAFEF);
        check("ack_cnt3", 64'(acks), 64'd3);
        cycle(1'b0, 1'b1, 1'b0, '0);
        check("rd0", 64'(Data_out), 64'h0FCB01AA);
        cycle(1'b0, 1'b1, 1'b0, '0);
        check("rd1", 64'(Data_out), 64'h0FCBCAFE);
        cycle(1'b0, 1'b1, 1'b0, '0);
        check("rd2", 64'(Data_out), 64'h011CAFEF);

        // overfill with 9 words, then drain
        acks = 0;
        for (int i = 1; i <= 9; i++) cycle(1'b1, 1'b0, 1'b0, DW'(i));
        check("ack_cnt8", 64'(acks), 64'd8);
        check("full_at8", 64'(Full_out), 64'd1);
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b0, 1'b1, 1'b0, '0);
            check("drain", 64'(Data_out), 64'(i));
        end
        check("empty_drained", 64'(Empty_out), 64'd1);

        // read at empty, then read+write at empty
        held = Data_out;
        cycle(1'b0, 1'b1, 1'b0, '0);
        check("rd_empty_hold", 64'(Data_out), 64'(held));
        cycle(1'b1, 1'b1, 1'b0, 32'hA5A5_0001);
        check("rw_empty_ack", 64'(ack_write), 64'd1);
        check("rw_empty_hold", 64'(Data_out), 64'(held));
        check("rw_empty_cnt", 64'(dut.cnt), 64'd1);

        // hold at cnt=4 across wrap with simultaneous read+write
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, $urandom);
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 1'b0, $urandom);
        check("steady_cnt4", 64'(dut.cnt), 64'd4);

        // fill to DEPTH then read+write: read wins, write dropped
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, $urandom);
        cycle(1'b1, 1'b1, 1'b0, $urandom);
        check("full_rw_ack", 64'(ack_write), 64'd0);
        check("full_rw_cnt", 64'(dut.cnt), 64'd7);

        // clear with a write pending at cnt=5
        cycle(1'b0, 1'b1, 1'b0, '0);
        cycle(1'b0, 1'b1, 1'b0, '0);
        check("pre_clr_cnt", 64'(dut.cnt), 64'd5);
        cycle(1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF);
        check("clr_cnt", 64'(dut.cnt), 64'd0);
        check("clr_ack", 64'(ack_write), 64'd0);
        check("clr_empty", 64'(Empty_out), 64'd1);

        // random traffic with rare clears
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom), 1'($urandom), ($urandom_range(0, 63) == 0), $urandom);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
